// File: rtl/grant_lock_fsm_pkg.sv
// Shared types, sizing constants and helpers for the grant lock stage.
package grant_lock_fsm_pkg;

    localparam int unsigned N        = 4;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned COOLDOWN = 2;

    localparam int unsigned ID_W  = $clog2(N);
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned CD_W  = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    // Highest set bit index; 0 for an all-zero vector.
    function automatic logic [ID_W-1:0] onehot_to_index(input logic [N-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/grant_lock_fsm_if.sv
// Grant/release inputs and ownership status outputs of the lock stage.
interface grant_lock_fsm_if;
    import grant_lock_fsm_pkg::*;

    logic [N-1:0]     grant_in;
    logic [N-1:0]     release_in;
    logic [N-1:0]     owner_onehot;
    logic [ID_W-1:0]  owner_id;
    logic             locked;
    logic             timeout_pulse;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output grant_in, release_in,
        input  owner_onehot, owner_id, locked, timeout_pulse, hold_cnt
    );

    modport slave (
        input  grant_in, release_in,
        output owner_onehot, owner_id, locked, timeout_pulse, hold_cnt
    );
endinterface

// File: rtl/grant_lock_fsm_prio_select.sv
// Combinational highest-set-bit picker: one-hot and binary index of the winner.
module grant_lock_fsm_prio_select
    import grant_lock_fsm_pkg::*;
(
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    onehot_c_o,
    output logic [ID_W-1:0] idx_c_o
);

    logic [ID_W-1:0] idx;

    always_comb begin
        idx        = onehot_to_index(req_i);
        idx_c_o    = idx;
        onehot_c_o = (req_i != '0) ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/grant_lock_fsm.sv
// Turns a momentary arbiter grant into a held ownership lock with hold timeout
// and a fixed cooldown before the next grant can be taken.
module grant_lock_fsm
    import grant_lock_fsm_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    grant_lock_fsm_if.slave bus
);

    state_e           state_q, state_d;
    logic [N-1:0]     owner_oh_q, owner_oh_d;
    logic [ID_W-1:0]  owner_id_q, owner_id_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CD_W-1:0]  cd_cnt_q, cd_cnt_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic [N-1:0]     sel_oh;
    logic [ID_W-1:0]  sel_idx;

    grant_lock_fsm_prio_select u_prio_select (
        .req_i      (bus.grant_in),
        .onehot_c_o (sel_oh),
        .idx_c_o    (sel_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_oh_q <= '0;
            owner_id_q <= '0;
            hold_cnt_q <= '0;
            cd_cnt_q   <= '0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_oh_q <= owner_oh_d;
            owner_id_q <= owner_id_d;
            hold_cnt_q <= hold_cnt_d;
            cd_cnt_q   <= cd_cnt_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d    = state_q;
        owner_oh_d = owner_oh_q;
        owner_id_d = owner_id_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.grant_in != '0) begin
                    state_d    = ST_LOCKED;
                    owner_oh_d = sel_oh;
                    owner_id_d = sel_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                // Owner release beats a coincident timeout.
                if ((bus.release_in & owner_oh_q) != '0) begin
                    state_d = ST_COOLDOWN;
                end else if (hold_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = ST_COOLDOWN;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt_q == CD_W'(COOLDOWN - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cd_cnt_d = (state_q == ST_COOLDOWN && state_d == ST_COOLDOWN)
                   ? cd_cnt_q + CD_W'(1) : '0;

        locked_d = (state_d == ST_LOCKED);
        if (!locked_d) begin
            owner_oh_d = '0;
            owner_id_d = '0;
            hold_cnt_d = '0;
        end
    end

    assign bus.owner_onehot  = owner_oh_q;
    assign bus.owner_id      = owner_id_q;
    assign bus.locked        = locked_q;
    assign bus.timeout_pulse = timeout_q;
    assign bus.hold_cnt      = hold_cnt_q;

endmodule
